// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXDATA (0x0), STATUS (0x4), BAUD_DIV (0x8)
// behind a load/store bus slot, with a circular TX FIFO feeding a baud-rate FSM.
module uart_tx_periph #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_7800,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    output logic [31:0] o_ld_data,
    output logic        o_hit,
    output logic        o_uart_tx
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_q, div_d;
    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q, tx_d;

    logic [1:0]    sel;
    logic          wr_txdata, wr_status, wr_div;
    logic          full, empty, push, pop;
    logic [7:0]    count_ext;
    logic          unused_bits;

    assign sel       = i_lsu_addr[3:2];
    assign o_hit     = (i_lsu_addr[31:4] == BASE_ADDR[31:4]) && (sel != 2'd3);
    assign wr_txdata = i_lsu_wren && o_hit && (sel == 2'd0);
    assign wr_status = i_lsu_wren && o_hit && (sel == 2'd1);
    assign wr_div    = i_lsu_wren && o_hit && (sel == 2'd2);

    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot.
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = wr_txdata && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign count_ext = 8'(count_q);
    assign o_uart_tx = tx_q;

    assign unused_bits = ^{i_lsu_addr[1:0], i_st_data[31:16]};

    always_comb begin
        o_ld_data = '0;
        if (o_hit) begin
            case (sel)
                2'd1:    o_ld_data = {16'b0, count_ext, 4'b0, ovf_q, empty, full,
                                      (state_q != IDLE)};
                2'd2:    o_ld_data = {16'b0, div_q};
                default: o_ld_data = '0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        div_d     = div_q;
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_txdata && full)
            ovf_d = 1'b1;
        else if (wr_status && i_st_data[3])
            ovf_d = 1'b0;

        if (wr_div)
            div_d = (i_st_data[15:0] == 16'd0) ? 16'd1 : i_st_data[15:0];

        // tx_d anticipates the next state so the line comes straight from a flop.
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d   = mem[rd_ptr_q];
                    bit_cnt_d = div_q - 16'd1;
                    state_d   = START;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_cnt_q == 16'd0) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    bit_cnt_d = div_q - 16'd1;
                    tx_d      = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt_q == 16'd0) begin
                    bit_cnt_d = div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt_q == 16'd0) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            div_q     <= DEFAULT_DIV;
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= i_st_data[7:0];
    end
endmodule
